// File: rtl/wind_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : wind_input_conditioner
// Brief   : Synchronises and debounces the wind switches, decodes a legal mode
//           and emits a one-cycle step tick. WIND_ILLEGAL_HOLD_EN makes sw=11
//           hold the current mode instead of decoding to calm.
// Revision: 1.0 - initial release
// ============================================================================
module wind_input_conditioner #(
  parameter int TICK_DIV        = 33554432,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] mode,
  output logic       tick,
  output logic       mode_changed,
  output logic       heartbeat
);

  localparam int c_tick_w = $clog2(TICK_DIV);
  localparam int c_cnt_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);

  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          cand_q, cand_d;
  logic [1:0]          stable_q, stable_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_tick_w-1:0] tick_cnt_q, tick_cnt_d;
  logic                tick_q, tick_d;
  logic [1:0]          mode_q, mode_d;
  logic                mode_changed_q, mode_changed_d;
  logic                heartbeat_q, heartbeat_d;

  logic                tick_edge;
  logic                apply;
  logic [1:0]          decoded;

  always_comb begin
`ifdef WIND_ILLEGAL_HOLD_EN
    apply   = (stable_q != 2'b11);
    decoded = stable_q;
`else
    apply   = 1'b1;
    decoded = (stable_q == 2'b11) ? 2'b00 : stable_q;
`endif
  end

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
    end else if (cand_q != stable_q) begin
      if (cnt_q == c_cnt_last) begin
        stable_d = cand_q;
      end else begin
        cnt_d = cnt_q + c_cnt_one;
      end
    end

    // Mode is only ever updated on the edge that raises tick, so the
    // downstream FSM sees mode, tick and mode_changed aligned.
    tick_edge      = (tick_cnt_q == c_tick_last);
    tick_cnt_d     = tick_edge ? '0 : tick_cnt_q + c_tick_one;
    tick_d         = tick_edge;
    mode_d         = mode_q;
    mode_changed_d = 1'b0;
    heartbeat_d    = heartbeat_q;
    if (tick_edge) begin
      heartbeat_d = ~heartbeat_q;
      if (apply) begin
        mode_d         = decoded;
        mode_changed_d = (decoded != mode_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      cand_q         <= '0;
      stable_q       <= '0;
      cnt_q          <= '0;
      tick_cnt_q     <= '0;
      tick_q         <= 1'b0;
      mode_q         <= 2'b00;
      mode_changed_q <= 1'b0;
      heartbeat_q    <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      cand_q         <= cand_d;
      stable_q       <= stable_d;
      cnt_q          <= cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_q         <= tick_d;
      mode_q         <= mode_d;
      mode_changed_q <= mode_changed_d;
      heartbeat_q    <= heartbeat_d;
    end
  end

  assign mode         = mode_q;
  assign tick         = tick_q;
  assign mode_changed = mode_changed_q;
  assign heartbeat    = heartbeat_q;

endmodule
`default_nettype wire

// File: tb/tb_wind_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_wind_input_conditioner
// Brief   : Randomised scoreboard bench for wind_input_conditioner.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wind_input_conditioner;

  localparam int TICK_DIV = 8;
  localparam int DB       = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] mode;
  logic       tick;
  logic       mode_changed;
  logic       heartbeat;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] md;
    logic       chg;
    logic       hb;
  } exp_t;

  exp_t sbq[$];

  wind_input_conditioner #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw),
    .mode(mode), .tick(tick), .mode_changed(mode_changed), .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Reference model: the input is seen two edges late; a value becomes
  // debounced once it has been the synchronised value for DB+1 samples in a
  // row; ticks fall on every TICK_DIV-th edge after reset.
  int         m_edge;
  logic [1:0] m_p1, m_p2, m_stable, m_mode, m_synced, m_dec;
  logic       m_hb, m_all;
  logic [1:0] m_win[$];
  exp_t       m_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edge = 0; m_p1 = 0; m_p2 = 0; m_stable = 0; m_mode = 0; m_hb = 0;
      m_win.delete();
      sbq.delete();
    end else begin
      m_edge++;
      m_synced = m_p2;
      m_p2 = m_p1;
      m_p1 = sw_raw;
      if (m_edge % TICK_DIV == 0) begin
        m_dec = m_stable;
        if (m_stable == 2'b11) begin
`ifdef WIND_ILLEGAL_HOLD_EN
          m_dec = m_mode;
`else
          m_dec = 2'b00;
`endif
        end
        m_hb = ~m_hb;
        m_e = {m_dec, (m_dec != m_mode), m_hb};
        m_mode = m_dec;
        sbq.push_back(m_e);
      end
      m_win.push_back(m_synced);
      if (m_win.size() > DB + 1) void'(m_win.pop_front());
      if (m_win.size() == DB + 1) begin
        m_all = 1'b1;
        foreach (m_win[i]) if (m_win[i] != m_win[0]) m_all = 1'b0;
        if (m_all) m_stable = m_win[0];
      end
    end
  end

  // Monitor: tick cycles are checked against the scoreboard, all other
  // cycles against the model's held mode/heartbeat with no change pulse.
  always @(posedge clk) begin
    exp_t got;
    #1;
    got = {mode, mode_changed, heartbeat};
    if (tick) begin
      if (sbq.size() == 0) begin
        chk("spurious_tick", 8'(tick), 8'h0);
      end else begin
        chk("tick_outputs", 8'(got), 8'(sbq.pop_front()));
      end
    end else begin
      chk("idle_outputs", 8'(got), 8'({m_mode, 1'b0, m_hb}));
    end
  end

  task automatic hold(input logic [1:0] v, input int n);
    sw_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mode", 8'(mode), 8'h0);
    chk("async_rst_tick", 8'(tick), 8'h0);
    chk("async_rst_chg", 8'(mode_changed), 8'h0);
    chk("async_rst_hb", 8'(heartbeat), 8'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mode", 8'(mode), 8'h0);
    chk("rst_tick", 8'(tick), 8'h0);
    chk("rst_chg", 8'(mode_changed), 8'h0);
    chk("rst_hb", 8'(heartbeat), 8'h0);
    sw_raw = 2'b01;
    reset  = 1'b0;
    hold(2'b01, 20);
    hold(2'b10, 3);
    hold(2'b00, 32);
    hold(2'b01, 20);
    hold(2'b11, 20);
    hold(2'b01, 12);
    hold(2'b10, 12);
    async_reset_check();
    hold(2'b00, 30);
    for (int p = 0; p < 400; p++) begin
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 14));
      if (p % 100 == 50) async_reset_check();
    end
    hold(sw_raw, 2 * TICK_DIV);
    chk("sb_drained", 8'(sbq.size()), 8'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
